regfile_param: RTL and testbench
================================

# regfile_param

Parametrised multi-ported register file for the processor datapath: one write port, two combinational read ports, configurable word width and depth, and an optional hardwired-zero entry 0. Unlike the previous fixed 32x32 file, it clears its own contents after reset or on request, using a sequential clear engine. It flags that with `busy`. It sits between decode (read addresses) and writeback (write port), and `busy` stalls the pipeline front end until the file is clean.

## Interface
- `WIDTH`, 32, data word width in bits (>= 1)
- `DEPTH`, 32, number of entries; must be a power of two, >= 2
- `AW`, `$clog2(DEPTH)`, address width; derived, never overridden
- `ZERO_REG`, 1, 1 = entry 0 is hardwired to zero; 0 = entry 0 is an ordinary register
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `clr`  in  1  request a full clear while running; single-cycle pulse, level also accepted
- `we3`  in  1  write enable for port 3
- `a1`, `a2`  in  AW  read addresses, ports 1 and 2
- `a3`  in  AW  write address
- `wd3`  in  WIDTH  write data
- `rd1`, `rd2`  out  WIDTH  read data, combinational
- `busy`  out  1  clear engine active; writes ignored, reads return 0

## Operation
- FSM has two states, CLEAR and RUN. A clear index `cidx[AW-1:0]` is held in a register.
- `reset` high at an edge: state <= CLEAR, cidx <= 0. Array contents are not touched on that edge.
- In CLEAR with `reset` low, each edge: rf[cidx] <= 0 and cidx <= cidx+1. When cidx == DEPTH-1, state <= RUN instead of incrementing.
- In RUN, each edge:
  - `clr`=1 → state <= CLEAR, cidx <= 0. The write on that edge is still performed if `we3`.
  - Otherwise, if `we3` → rf[a3] <= wd3.
- ZERO_REG=1: writes to a3==0 are discarded, and a read of address 0 returns 0 in every state.
- `busy` = (state == CLEAR). This is a registered-state decode with no combinational path from inputs.
- Reads while `busy`: `rd1` and `rd2` = 0 regardless of address. `we3` is ignored and `clr` has no effect.
- Reads in RUN: rd1 = rf[a1] and rd2 = rf[a2], except for the zero-register and bypass rules.
- Both read ports may address the same entry, and each independently returns the same value.
- Width rules: `wd3` is stored unmodified. No sign or zero extension happens inside the block.

## Timing
- Reset values: state=CLEAR, cidx=0, busy=1, rd1=rd2=0.
- Clear latency: exactly DEPTH rising edges with `reset` low. `busy` falls after the DEPTH-th such edge; for DEPTH=32, the first write is accepted on edge 33.
- Reset reasserted mid-clear: cidx returns to 0, the clear restarts, and busy stays 1.
- `clr` in RUN: busy rises on the following edge. The clear then takes DEPTH edges, as after reset.
- Write latency: the value is visible on the read ports the cycle after the edge that writes it. The same-cycle case depends on `REGFILE_BYPASS_EN`.
- Read latency: combinational, zero cycles from the address.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: write-to-read forwarding. In RUN, if we3=1 and a3==a1, then rd1 = wd3 in the same cycle; the same applies to port 2 with a2. The exception is a3==0 with ZERO_REG=1, which still reads 0. No bypass while busy.
- Undefined: no forwarding. A same-cycle read of the address being written returns the old contents until the edge.

## Test plan
- Reset, DEPTH=32 → busy=1 for 32 edges after reset falls, then 0; every address reads 0.
- After the clear, write 0xDEADBEEF to entry 5 → next cycle rd1 (a1=5) = 0xDEADBEEF, and rd2 (a2=5) matches.
- ZERO_REG=1: write 0x12345678 to entry 0 → rd1 (a1=0) = 0. ZERO_REG=0: same write reads back 0x12345678.
- Same-cycle write 0xA5A5A5A5 to entry 7 with a1=7, entry 7 previously 0x1 → with the macro, rd1 = 0xA5A5A5A5 before the edge. Without the macro, rd1 = 0x1 before the edge and 0xA5A5A5A5 after.
- Fill entries 1..31, pulse `clr` → busy=1 for 32 edges. Writes with we3=1 in that window are dropped, and afterwards every entry reads 0.
- Assert `reset` at clear edge 10, release → busy lasts a further full 32 edges, and all entries read 0 afterwards.
- WIDTH=8, DEPTH=4 instance: write 0xFF to entry 3 → reads back 0xFF, and the clear takes exactly 4 edges.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised 1W/2R register file with a sequential clear engine (busy while clearing).
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_param #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  localparam int unsigned AW      = $clog2(DEPTH),
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             we3,
  input  logic [AW-1:0]    a1,
  input  logic [AW-1:0]    a2,
  input  logic [AW-1:0]    a3,
  input  logic [WIDTH-1:0] wd3,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             busy
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cidx_q, cidx_d;
  logic [WIDTH-1:0] rf [DEPTH];

  logic             wen;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;

  always_comb begin
    state_d = state_q;
    cidx_d  = cidx_q;
    wen     = 1'b0;
    waddr   = a3;
    wdata   = wd3;
    if (reset) begin
      // Reset only restarts the engine; the array is left alone on this edge.
      state_d = StClear;
      cidx_d  = '0;
    end else begin
      unique case (state_q)
        StClear: begin
          wen   = 1'b1;
          waddr = cidx_q;
          wdata = '0;
          if (cidx_q == AW'(DEPTH - 1)) begin
            state_d = StRun;
          end else begin
            cidx_d = cidx_q + AW'(1);
          end
        end
        StRun: begin
          if (clr) begin
            state_d = StClear;
            cidx_d  = '0;
          end
          // A write coinciding with a clear request still lands.
          if (we3 && !(ZERO_REG && (a3 == '0))) begin
            wen = 1'b1;
          end
        end
        default: state_d = StClear;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cidx_q  <= cidx_d;
  end

  always_ff @(posedge clk) begin
    if (wen) begin
      rf[waddr] <= wdata;
    end
  end

  assign busy = (state_q == StClear);

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (state_q == StRun) begin
      if (!(ZERO_REG && (a1 == '0))) begin
        rd1 = rf[a1];
`ifdef REGFILE_BYPASS_EN
        if (we3 && (a3 == a1)) begin
          rd1 = wd3;
        end
`endif
      end
      if (!(ZERO_REG && (a2 == '0))) begin
        rd2 = rf[a2];
`ifdef REGFILE_BYPASS_EN
        if (we3 && (a3 == a2)) begin
          rd2 = wd3;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: 32x32 instances (ZERO_REG=1 and 0) and an 8x4 instance.
// Expected read data flows through a scoreboard queue; busy windows are counted in edges.
module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32x32 instances share stimulus
  logic        reset, clr, we3;
  logic [4:0]  a1, a2, a3;
  logic [31:0] wd3;
  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
  logic        busy_0, busy_1;

  // 8x4 instance
  logic        reset_s, clr_s, we3_s;
  logic [1:0]  a1_s, a2_s, a3_s;
  logic [7:0]  wd3_s, rd1_s, rd2_s;
  logic        busy_s;

  regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1)) u_rf0 (
    .clk(clk), .reset(reset), .clr(clr), .we3(we3), .a1(a1), .a2(a2), .a3(a3),
    .wd3(wd3), .rd1(rd1_0), .rd2(rd2_0), .busy(busy_0)
  );

  regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b0)) u_rf1 (
    .clk(clk), .reset(reset), .clr(clr), .we3(we3), .a1(a1), .a2(a2), .a3(a3),
    .wd3(wd3), .rd1(rd1_1), .rd2(rd2_1), .busy(busy_1)
  );

  regfile_param #(.WIDTH(8), .DEPTH(4), .ZERO_REG(1'b1)) u_rf_s (
    .clk(clk), .reset(reset_s), .clr(clr_s), .we3(we3_s), .a1(a1_s), .a2(a2_s), .a3(a3_s),
    .wd3(wd3_s), .rd1(rd1_s), .rd2(rd2_s), .busy(busy_s)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  sb_t e;
  int  n_tests = 0;
  int  n_fail  = 0;
  int  n;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a1 = 5'd5; a2 = 5'd9;
    step(); step();
    n_tests++;
    if (busy_0 !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy: got %b want 1", busy_0);
    end
    sb_q.push_back('{"reset_rd1", 32'h0});
    sb_q.push_back('{"reset_rd2", 32'h0});
    e = sb_q.pop_front(); n_tests++;
    if (rd1_0 !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rd1_0, e.exp); end
    e = sb_q.pop_front(); n_tests++;
    if (rd2_0 !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rd2_0, e.exp); end
    reset = 1'b0;
    n = 0;
    while (busy_0 && n < 100) begin step(); n++; end
    n_tests++;
    if (n !== 32) begin n_fail++; $display("FAIL reset_clear_edges: got %0d want 32", n); end
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i); a2 = 5'(31 - i);
      sb_q.push_back('{"init_rd1", 32'h0});
      sb_q.push_back('{"init_rd2", 32'h0});
      #1;
      e = sb_q.pop_front(); n_tests++;
      if (rd1_0 !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got %h want %h", e.name, i, rd1_0, e.exp); end
      e = sb_q.pop_front(); n_tests++;
      if (rd2_0 !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got %h want %h", e.name, i, rd2_0, e.exp); end
    end
  endtask

  task automatic test_write();
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF;
    step();
    we3 = 1'b0; a1 = 5'd5; a2 = 5'd5;
    sb_q.push_back('{"write_rd1", 32'hDEADBEEF});
    sb_q.push_back('{"write_rd2", 32'hDEADBEEF});
    #1;
    e = sb_q.pop_front(); n_tests++;
    if (rd1_0 !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rd1_0, e.exp); end
    e = sb_q.pop_front(); n_tests++;
    if (rd2_0 !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rd2_0, e.exp); end
  endtask

  task automatic test_zero_reg();
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'h12345678;
    step();
    we3 = 1'b0; a1 = 5'd0; a2 = 5'd0;
    sb_q.push_back('{"zero_rd1_zr1", 32'h0});
    sb_q.push_back('{"zero_rd1_zr0", 32'h12345678});
    sb_q.push_back('{"zero_rd2_zr0", 32'h12345678});
    #1;
    e = sb_q.pop_front(); n_tests++;
    if (rd1_0 !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rd1_0, e.exp); end
    e = sb_q.pop_front(); n_tests++;
    if (rd1_1 !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rd1_1, e.exp); end
    e = sb_q.pop_front(); n_tests++;
    if (rd2_1 !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rd2_1, e.exp); end
  endtask

  task automatic test_bypass();
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'h1;
    step();
    wd3 = 32'hA5A5A5A5; a1 = 5'd7; a2 = 5'd5;
`ifdef REGFILE_BYPASS_EN
    sb_q.push_back('{"same_cycle_rd1", 32'hA5A5A5A5});
`else
    sb_q.push_back('{"same_cycle_rd1", 32'h1});
`endif
    sb_q.push_back('{"same_cycle_rd2_other", 32'hDEADBEEF});
    #1;
    e = sb_q.pop_front(); n_tests++;
    if (rd1_0 !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rd1_0, e.exp); end
    e = sb_q.pop_front(); n_tests++;
    if (rd2_0 !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rd2_0, e.exp); end
    step();
    we3 = 1'b0;
    sb_q.push_back('{"after_edge_rd1", 32'hA5A5A5A5});
    #1;
    e = sb_q.pop_front(); n_tests++;
    if (rd1_0 !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rd1_0, e.exp); end
  endtask

  task automatic test_clr();
    for (int i = 1; i < 32; i++) begin
      we3 = 1'b1; a3 = 5'(i); wd3 = 32'h100 + 32'(i);
      step();
    end
    we3 = 1'b0; a1 = 5'd9;
    sb_q.push_back('{"fill_rd1", 32'h109});
    #1;
    e = sb_q.pop_front(); n_tests++;
    if (rd1_0 !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rd1_0, e.exp); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_tests++;
    if (busy_0 !== 1'b1) begin n_fail++; $display("FAIL clr_busy: got %b want 1", busy_0); end
    sb_q.push_back('{"busy_rd1", 32'h0});
    #1;
    e = sb_q.pop_front(); n_tests++;
    if (rd1_0 !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rd1_0, e.exp); end
    n = 0;
    while (busy_0 && n < 100) begin
      we3 = 1'b1; a3 = 5'(n + 1); wd3 = 32'hFFFF0000;
      step(); n++;
    end
    we3 = 1'b0;
    n_tests++;
    if (n !== 32) begin n_fail++; $display("FAIL clr_edges: got %0d want 32", n); end
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i); a2 = 5'(i);
      sb_q.push_back('{"post_clr_rd1", 32'h0});
      sb_q.push_back('{"post_clr_rd2_zr0", 32'h0});
      #1;
      e = sb_q.pop_front(); n_tests++;
      if (rd1_0 !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got %h want %h", e.name, i, rd1_0, e.exp); end
      e = sb_q.pop_front(); n_tests++;
      if (rd2_1 !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got %h want %h", e.name, i, rd2_1, e.exp); end
    end
  endtask

  task automatic test_reset_mid_clear();
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'h33;
    step();
    a3 = 5'd30; wd3 = 32'h3030;
    step();
    we3 = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++;
    if (busy_0 !== 1'b1) begin n_fail++; $display("FAIL midreset_busy: got %b want 1", busy_0); end
    n = 0;
    while (busy_0 && n < 100) begin step(); n++; end
    n_tests++;
    if (n !== 32) begin n_fail++; $display("FAIL midreset_edges: got %0d want 32", n); end
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i); a2 = 5'(i);
      sb_q.push_back('{"midreset_rd1", 32'h0});
      sb_q.push_back('{"midreset_rd1_zr0", 32'h0});
      #1;
      e = sb_q.pop_front(); n_tests++;
      if (rd1_0 !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got %h want %h", e.name, i, rd1_0, e.exp); end
      e = sb_q.pop_front(); n_tests++;
      if (rd1_1 !== e.exp) begin n_fail++; $display("FAIL %s[%0d]: got %h want %h", e.name, i, rd1_1, e.exp); end
    end
  endtask

  task automatic test_small();
    reset_s = 1'b0;
    n = 0;
    while (busy_s && n < 20) begin step(); n++; end
    n_tests++;
    if (n !== 4) begin n_fail++; $display("FAIL small_reset_edges: got %0d want 4", n); end
    we3_s = 1'b1; a3_s = 2'd3; wd3_s = 8'hFF;
    step();
    we3_s = 1'b0; a1_s = 2'd3; a2_s = 2'd3;
    sb_q.push_back('{"small_rd1", 32'hFF});
    sb_q.push_back('{"small_rd2", 32'hFF});
    #1;
    e = sb_q.pop_front(); n_tests++;
    if (32'(rd1_s) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rd1_s, e.exp); end
    e = sb_q.pop_front(); n_tests++;
    if (32'(rd2_s) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rd2_s, e.exp); end
    clr_s = 1'b1;
    step();
    clr_s = 1'b0;
    n = 0;
    while (busy_s && n < 20) begin step(); n++; end
    n_tests++;
    if (n !== 4) begin n_fail++; $display("FAIL small_clr_edges: got %0d want 4", n); end
    sb_q.push_back('{"small_post_clr", 32'h0});
    #1;
    e = sb_q.pop_front(); n_tests++;
    if (32'(rd1_s) !== e.exp) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, rd1_s, e.exp); end
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; we3 = 1'b0;
    a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
    reset_s = 1'b1; clr_s = 1'b0; we3_s = 1'b0;
    a1_s = '0; a2_s = '0; a3_s = '0; wd3_s = '0;
    test_reset();
    test_write();
    test_zero_reg();
    test_bypass();
    test_clr();
    test_reset_mid_clear();
    test_small();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
